// File: rtl/serializer_pkg.sv
// serializer_pkg: types and helpers shared by the POY x POX output serializer
// controller and its neighbours.
//   state_e : controller FSM states
//   row_w() : row-index width, max(1, $clog2(poy))
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,  // serializer empty, awaiting a tile
    DRAIN = 2'd2,  // serializer holds a tile; row_idx is the row at its head
    TAIL  = 2'd3   // last row in flight to the serializer output register
  } state_e;

  function automatic int row_w(input int poy);
    return (poy <= 2) ? 1 : $clog2(poy);
  endfunction

endpackage

// File: rtl/serializer_ctrl.sv
// serializer_ctrl: sequences the POY x POX output serializer.
// Accepts finished MAC tiles over valid/ready, pulses the serializer load,
// steers its shift select so one POX-wide row leaves per cycle, and emits a
// row-valid/index sideband aligned with the serializer's registered output.
// Counts tiles per layer and pulses done when the layer is complete.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle layer start (ignored while busy)
//   cfg_num_tiles     tiles in the layer, sampled on an accepted start
//   mac_valid/ready   tile handshake from the MAC array controller
//   ser_load/shift    serializer mac_output_valid / mux_sel
//   out_valid/row/tile/last  sideband for serializer_out
//   busy, done        layer in progress / one-cycle completion pulse
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter  int POY    = 3,
  parameter  int TILE_W = 16,
  localparam int ROW_W  = row_w(POY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              mac_valid,
  output logic              mac_ready,
  output logic              ser_load,
  output logic              ser_shift,
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_row,
  output logic [TILE_W-1:0] out_tile,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(POY - 1);

  state_e            state_q;
  logic [ROW_W-1:0]  row_idx_q;
  logic [TILE_W-1:0] tiles_left_q;
  logic [TILE_W-1:0] tile_cnt_q;   // index the next loaded tile will get
  logic [TILE_W-1:0] tile_idx_q;   // index of the tile in the serializer
  logic              out_valid_q, out_last_q, busy_q, done_q;
  logic [ROW_W-1:0]  out_row_q;
  logic [TILE_W-1:0] out_tile_q;
  logic              at_last_row;

  assign at_last_row = (row_idx_q == LAST_ROW);

  // Ready comes only from registered state so the MAC side can use it
  // without a combinational loop through mac_valid. Loading on the last
  // DRAIN row keeps the output stream gap-free between tiles.
  assign mac_ready = (tiles_left_q != '0) &&
                     ((state_q == WAIT) || ((state_q == DRAIN) && at_last_row));
  assign ser_load  = mac_valid && mac_ready;
  assign ser_shift = (state_q == DRAIN) && !at_last_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_idx_q    <= '0;
      tiles_left_q <= '0;
      tile_cnt_q   <= '0;
      tile_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_tile_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Sideband is the head-of-serializer view delayed by the serializer's
      // output register.
      out_valid_q <= (state_q == DRAIN);
      out_row_q   <= row_idx_q;
      out_tile_q  <= tile_idx_q;
      out_last_q  <= (state_q == DRAIN) && at_last_row && (tiles_left_q == '0);
      done_q      <= 1'b0;

      if (ser_load) begin
        state_q      <= DRAIN;
        row_idx_q    <= '0;
        tiles_left_q <= tiles_left_q - TILE_W'(1);
        tile_idx_q   <= tile_cnt_q;
        tile_cnt_q   <= tile_cnt_q + TILE_W'(1);
      end else begin
        unique case (state_q)
          IDLE: begin
            // busy_q still high here only in the done cycle; start is
            // ignored then, and busy drops afterwards.
            if (start && !busy_q) begin
              if (cfg_num_tiles != '0) begin
                state_q      <= WAIT;
                tiles_left_q <= cfg_num_tiles;
                tile_cnt_q   <= '0;
                busy_q       <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end else begin
              busy_q <= 1'b0;
            end
          end
          WAIT: ;
          DRAIN: begin
            if (!at_last_row) row_idx_q <= row_idx_q + ROW_W'(1);
            else              state_q   <= (tiles_left_q != '0) ? WAIT : TAIL;
          end
          TAIL: begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_tile  = out_tile_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Directed bench: POY=3 and POY=1 controllers, per-cycle traces of each
// output packed into bit masks and compared with hand-derived timelines.
module tb_serializer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg = '0;
  logic        start3 = 1'b0, mv3 = 1'b0, start1 = 1'b0, mv1 = 1'b0;

  logic        rdy3, ld3, sh3, ov3, last3, busy3, done3;
  logic [1:0]  row3;
  logic [15:0] tile3;
  logic        rdy1, ld1, sh1, ov1, last1, busy1, done1;
  logic [0:0]  row1;
  logic [15:0] tile1;

  int n_cmp = 0, n_err = 0;
  logic [31:0] o_rdy, o_ld, o_sh, o_ov, o_last, o_busy, o_done, o_rows, o_tiles;

  always #5 clk = ~clk;

  serializer_ctrl #(.POY(3), .TILE_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cfg_num_tiles(cfg),
    .mac_valid(mv3), .mac_ready(rdy3), .ser_load(ld3), .ser_shift(sh3),
    .out_valid(ov3), .out_row(row3), .out_tile(tile3), .out_last(last3),
    .busy(busy3), .done(done3));

  serializer_ctrl #(.POY(1), .TILE_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cfg_num_tiles(cfg),
    .mac_valid(mv1), .mac_ready(rdy1), .ser_load(ld1), .ser_shift(sh1),
    .out_valid(ov1), .out_row(row1), .out_tile(tile1), .out_last(last1),
    .busy(busy1), .done(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 16-cycle scenario; cycle c starts just after the c-th posedge. start and
  // mac_valid go only to the selected DUT; rst is shared.
  task automatic run(input bit sel, input logic [15:0] n,
                     input logic [31:0] st_m, input logic [31:0] mv_m,
                     input logic [31:0] rs_m);
    o_rdy = '0; o_ld = '0; o_sh = '0; o_ov = '0; o_last = '0;
    o_busy = '0; o_done = '0; o_rows = '0; o_tiles = '0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      rst    = rs_m[c];
      cfg    = (c == 0) ? n : 16'd7;
      start3 = !sel && st_m[c];
      start1 = sel && st_m[c];
      mv3    = !sel && mv_m[c];
      mv1    = sel && mv_m[c];
      @(negedge clk);
      if (sel) begin
        o_rdy[c] = rdy1; o_ld[c] = ld1; o_sh[c] = sh1; o_ov[c] = ov1;
        o_last[c] = last1; o_busy[c] = busy1; o_done[c] = done1;
        if (ov1) begin
          o_rows  = (o_rows << 2) | 32'(row1);
          o_tiles = (o_tiles << 4) | 32'(tile1[3:0]);
        end
      end else begin
        o_rdy[c] = rdy3; o_ld[c] = ld3; o_sh[c] = sh3; o_ov[c] = ov3;
        o_last[c] = last3; o_busy[c] = busy3; o_done[c] = done3;
        if (ov3) begin
          o_rows  = (o_rows << 2) | 32'(row3);
          o_tiles = (o_tiles << 4) | 32'(tile3[3:0]);
        end
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; start3 = 1'b0; start1 = 1'b0; mv3 = 1'b0; mv1 = 1'b0;
  endtask

  task automatic expect_trace(input string nm,
      input logic [31:0] rdy, input logic [31:0] ld, input logic [31:0] sh,
      input logic [31:0] ov, input logic [31:0] lst, input logic [31:0] bsy,
      input logic [31:0] dn, input logic [31:0] rows, input logic [31:0] tiles);
    chk({nm, ".mac_ready"}, o_rdy, rdy);
    chk({nm, ".ser_load"},  o_ld, ld);
    chk({nm, ".ser_shift"}, o_sh, sh);
    chk({nm, ".out_valid"}, o_ov, ov);
    chk({nm, ".out_last"},  o_last, lst);
    chk({nm, ".busy"},      o_busy, bsy);
    chk({nm, ".done"},      o_done, dn);
    chk({nm, ".out_row"},   o_rows, rows);
    chk({nm, ".out_tile"},  o_tiles, tiles);
  endtask

  task automatic expect_reset(input string nm);
    chk({nm, ".ctl3"}, {25'd0, rdy3, ld3, sh3, ov3, last3, busy3, done3}, 32'd0);
    chk({nm, ".row3"}, 32'(row3), 32'd0);
    chk({nm, ".tile3"}, 32'(tile3), 32'd0);
    chk({nm, ".ctl1"}, {25'd0, rdy1, ld1, sh1, ov1, last1, busy1, done1}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // One tile: load@1, shift@2,3, rows@3..5, last@5, done@6.
    run(0, 16'd1, 32'h1, 32'h2, 32'h0);
    expect_trace("one_tile", 32'h2, 32'h2, 32'hC, 32'h38, 32'h20, 32'h7E,
                 32'h40, 32'h06, 32'h000);

    // Two tiles, mac_valid held: loads@1,4, rows gap-free 3..8, done@9.
    run(0, 16'd2, 32'h1, 32'hFFFE, 32'h0);
    expect_trace("b2b", 32'h12, 32'h12, 32'h6C, 32'h1F8, 32'h100, 32'h3FE,
                 32'h200, 32'h186, 32'h000111);

    // Reset after a run must clear the sideband left holding row 2 / tile 1.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expect_reset("reset_after_run");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two tiles, second mac_valid late at cycle 8: WAIT 5..8, rows resume @10.
    run(0, 16'd2, 32'h1, 32'h102, 32'h0);
    expect_trace("late", 32'h1F2, 32'h102, 32'h60C, 32'h1C38, 32'h1000,
                 32'h3FFE, 32'h2000, 32'h186, 32'h000111);

    // Zero tiles: done @1, never loads, busy never rises.
    run(0, 16'd0, 32'h1, 32'hFFFF, 32'h0);
    expect_trace("zero", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h2, 32'h0, 32'h0);

    // rst during DRAIN row 1 (cycle 3): everything quiet from cycle 4.
    run(0, 16'd2, 32'h1, 32'hFFFE, 32'h8);
    expect_trace("abort", 32'h2, 32'h2, 32'hC, 32'h8, 32'h0, 32'hE,
                 32'h0, 32'h0, 32'h0);

    // Fresh start after the abort runs normally.
    run(0, 16'd1, 32'h1, 32'h2, 32'h0);
    expect_trace("restart", 32'h2, 32'h2, 32'hC, 32'h38, 32'h20, 32'h7E,
                 32'h40, 32'h06, 32'h000);

    // Extra starts at 3 (mid-layer) and 6 (done cycle) are ignored.
    run(0, 16'd1, 32'h49, 32'hFFFE, 32'h0);
    expect_trace("start_busy", 32'h2, 32'h2, 32'hC, 32'h38, 32'h20, 32'h7E,
                 32'h40, 32'h06, 32'h000);

    // POY=1, three tiles: loads@1,2,3, never shifts, one row per tile.
    run(1, 16'd3, 32'h5, 32'hFFFE, 32'h0);
    expect_trace("poy1", 32'hE, 32'hE, 32'h0, 32'h38, 32'h20, 32'h7E,
                 32'h40, 32'h0, 32'h012);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_ctrl.md
# serializer_ctrl

- Sequences the POY×POX output serializer: accepts finished MAC tiles over a valid/ready handshake and pulses the serializer's load input.
- Drives the serializer's shift select so the tile leaves one POX-wide row per cycle.
- Produces a row-valid/index sideband aligned to the serializer's registered output.
- Sits between the MAC array controller and the output write buffer; counts tiles per layer and signals layer completion.

## Interface
- POY, default 3: rows per tile (serializer depth); must be ≥1.
- TILE_W, default 16: width of tile count/index.
- ROW_W, derived: max(1, $clog2(POY)).

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a layer, latches cfg_num_tiles; ignored while busy.
- cfg_num_tiles  in  TILE_W  tiles in the layer.
- mac_valid  in  1  MAC tile result available.
- mac_ready  out  1  controller will load the tile this cycle.
- ser_load  out  1  to serializer mac_output_valid.
- ser_shift  out  1  to serializer mux_sel.
- out_valid  out  1  serializer_out holds a valid row this cycle.
- out_row  out  ROW_W  row index of serializer_out.
- out_tile  out  TILE_W  tile index of serializer_out.
- out_last  out  1  out_valid row is row POY-1 of the last tile.
- busy  out  1  layer in progress (start accepted, done not yet pulsed).
- done  out  1  one-cycle layer-complete pulse.

## Operation
- States: IDLE, WAIT (serializer empty, awaiting tile), DRAIN (serializer holds tile, row_idx = row at serializer head), TAIL (last row in flight to output register).
- IDLE: start & cfg_num_tiles≠0 → WAIT, tiles_left=cfg_num_tiles, tile_idx=0. start & cfg_num_tiles=0 → done pulses next cycle, stays IDLE.
- mac_ready = tiles_left≠0 & (state==WAIT | (state==DRAIN & row_idx==POY-1)); depends only on registered state, never on mac_valid.
- ser_load = mac_valid & mac_ready. On load: → DRAIN, row_idx=0, tiles_left−1, tile_idx of loaded tile recorded.
- DRAIN, row_idx<POY-1: ser_shift=1, row_idx+1.
- DRAIN, row_idx==POY-1, no load: ser_shift=0.
  - tiles_left≠0 → WAIT.
  - tiles_left==0 → TAIL.
- TAIL: one cycle, → IDLE, done pulses following cycle.
- ser_load and ser_shift never both high. POY=1: ser_shift never asserts.
- Sideband: out_valid/out_row/out_tile are the DRAIN flag/row_idx/tile_idx registered one cycle. out_last = out_valid & out_row==POY-1 & last tile.
- No output backpressure: serializer output register updates every cycle, so consumer must accept every out_valid row.

## Timing
- Reset: state IDLE. mac_ready, ser_load, ser_shift, out_valid, out_last, busy, done = 0. out_row, out_tile, counters = 0.
- rst mid-layer aborts immediately; serializer is reset by the same rst.
- Load at cycle t: head row r in cycles t+1+r; out_valid row r in cycle t+2+r; load→first row latency 2.
- Back-to-back tiles: next load allowed in cycle t+POY, so output is gap-free at one row/cycle; tile throughput is POY cycles.
- done: exactly one cycle, the cycle after out_last.
- busy: high from cycle after accepted start through the done cycle.
- start during busy has no effect; cfg_num_tiles sampled only on accepted start.

## Structure
- Shared package (serializer_pkg): state enum {IDLE, WAIT, DRAIN, TAIL}, row-width function max(1,$clog2(POY)).
- No sub-module.
- Instantiated beside Serializer with identical POY; ser_load/ser_shift wire directly to mac_output_valid/mux_sel.

## Test plan
- POY=3, num_tiles=1: start@0, mac_valid@1 → ser_load@1, ser_shift@2,3, out_valid@3,4,5 rows 0,1,2, out_last@5, done@6.
- num_tiles=2, mac_valid held high → loads @1 and @4; out_valid continuous 3..8, out_tile 0,0,0,1,1,1; done@9.
- num_tiles=2, second mac_valid late (cycle 8) → WAIT holds mac_ready=1, no shift; rows resume at cycle 10; no spurious out_valid.
- cfg_num_tiles=0 → no ser_load, done one cycle after start, busy never rises.
- rst asserted during DRAIN row 1 → next cycle all outputs 0, IDLE; new start then works normally.
- start pulsed while busy, and POY=1 run → ignored (tile count unchanged); POY=1: ser_shift never asserts, one row per tile.
